// File: rtl/rbcp_register_responder.sv
// rbcp_register_responder
//   Slave end of the SiTCP RBCP bus. Host register accesses are decoded into
//   a bank of byte-wide read/write control registers followed by a block of
//   read-only status bytes. Every accepted access takes a fixed three-state
//   walk IDLE -> DECODE -> RESP, so a strobe in cycle T is acknowledged in
//   cycle T+2. Unmapped accesses are never acknowledged (SiTCP times them out)
//   and are counted in a saturating miss counter.
//
// Ports
//   clk, rst          SiTCP user clock, synchronous active-high reset
//   rbcp_we/re        one-cycle write/read strobes (both high -> write)
//   rbcp_wd           write data, valid with rbcp_we
//   rbcp_addr         byte address, valid with either strobe
//   rbcp_rd           read data, forced to 0 whenever rbcp_ack is low
//   rbcp_ack          one-cycle acknowledge for mapped accesses
//   ctrl_q            RW bytes, byte i at [8*i+7:8*i]
//   ctrl_wr_pulse     one-cycle pulse per RW byte written
//   status_d          RO bytes, byte j at [8*j+7:8*j]
//   status_rd_pulse   one-cycle pulse per RO byte read (clear-on-read hook)
//   miss_cnt          saturating count of unmapped accesses
module rbcp_register_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          N_RW         = 16,
    parameter int          N_RO         = 8,
    parameter logic [7:0]  RW_RESET_VAL = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rbcp_we,
    input  logic                rbcp_re,
    input  logic [7:0]          rbcp_wd,
    input  logic [31:0]         rbcp_addr,
    output logic [7:0]          rbcp_rd,
    output logic                rbcp_ack,
    output logic [N_RW*8-1:0]   ctrl_q,
    output logic [N_RW-1:0]     ctrl_wr_pulse,
    input  logic [N_RO*8-1:0]   status_d,
    output logic [N_RO-1:0]     status_rd_pulse,
    output logic [7:0]          miss_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              vld_p0;
    logic [31:0]       off_p1;
    logic [7:0]        wd_p1;
    logic              wr_p1;

    logic [N_RW-1:0]   rw_hot;
    logic [N_RO-1:0]   ro_hot;
    logic              hit;
    logic [7:0]        rd_mux;

    logic              hit_p2;
    logic [7:0]        data_p2;
    logic [N_RW-1:0]   wr_pulse_p2;
    logic [N_RO-1:0]   rd_pulse_p2;

    logic [N_RW*8-1:0] ctrl_reg;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Strobes are only taken in IDLE; anything arriving mid-access is dropped.
    assign vld_p0 = (state == IDLE) && (rbcp_we || rbcp_re);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vld_p0) state_next = DECODE;
            DECODE:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- stage p0 -> p1: latch request; offset wraps modulo 2^32 ----
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            off_p1 <= rbcp_addr - BASE_ADDR;
            wd_p1  <= rbcp_wd;
            wr_p1  <= rbcp_we;
        end
    end

    // One-hot decode of the latched offset; full 32-bit compares so that
    // addresses below BASE_ADDR (which wrap high) never alias into the map.
    always_comb begin
        rw_hot = '0;
        ro_hot = '0;
        rd_mux = '0;
        for (int i = 0; i < N_RW; i++) begin
            rw_hot[i] = (off_p1 == 32'(i));
            if (rw_hot[i]) rd_mux = rd_mux | ctrl_reg[8*i +: 8];
        end
        for (int j = 0; j < N_RO; j++) begin
            ro_hot[j] = (off_p1 == 32'(N_RW + j));
            if (ro_hot[j]) rd_mux = rd_mux | status_d[8*j +: 8];
        end
        hit = (|rw_hot) || (|ro_hot);
    end

    // ---- stage p1 -> p2: register response, status_d sampled here ----
    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            hit_p2      <= hit;
            data_p2     <= wr_p1 ? 8'h00 : rd_mux;
            wr_pulse_p2 <= wr_p1 ? rw_hot : '0;
            rd_pulse_p2 <= wr_p1 ? '0 : ro_hot;
        end
    end

    // RW bytes update on the DECODE edge so ctrl_q shows them from T+2.
    // Writes that decode to RO offsets match no rw_hot bit and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg <= {N_RW{RW_RESET_VAL}};
        end else if (state == DECODE && wr_p1) begin
            for (int i = 0; i < N_RW; i++) begin
                if (rw_hot[i]) ctrl_reg[8*i +: 8] <= wd_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt <= 8'h00;
        end else if (state == DECODE && !hit) begin
            miss_cnt <= sat_inc(miss_cnt);
        end
    end

    // ---- stage p2: outputs are valid only while in RESP ----
    always_comb begin
        rbcp_ack        = 1'b0;
        rbcp_rd         = 8'h00;
        ctrl_wr_pulse   = '0;
        status_rd_pulse = '0;
        if (state == RESP && hit_p2) begin
            rbcp_ack        = 1'b1;
            rbcp_rd         = data_p2;
            ctrl_wr_pulse   = wr_pulse_p2;
            status_rd_pulse = rd_pulse_p2;
        end
    end

    assign ctrl_q = ctrl_reg;

endmodule
